vga_scanout: RTL and testbench
==============================

# vga_scanout

VGA raster generator and pixel-pipeline front end for the `final_project_soc` color mapper. It runs at a 640x480@60 Hz timing from the 50 MHz system clock using a 25 MHz pixel enable, and presents each raster coordinate to the SoC on `tt_cm_x`/`tt_cm_y`. It then samples the returned `tt_cm_r/g/b` after a fixed mapper latency and drives the VGA DAC pins with sync and blank aligned to the pixel data.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `CM_LAT`, 1, color-mapper latency in pixel ticks, legal range 0..4
- `clk`  in  1  50 MHz system clock
- `reset`  in  1  synchronous, active-high
- `tt_cm_x`  out  10  horizontal coordinate presented to the mapper
- `tt_cm_y`  out  10  vertical coordinate presented to the mapper
- `tt_cm_r`, `tt_cm_g`, `tt_cm_b`  in  8 each  mapper colour for the coordinate presented `CM_LAT` ticks earlier
- `vga_clk`  out  1  25 MHz DAC clock
- `vga_hs`, `vga_vs`  out  1 each  syncs, active-low
- `vga_blank_n`  out  1  low outside the visible area
- `vga_sync_n`  out  1  constant 0
- `vga_r`, `vga_g`, `vga_b`  out  8 each  DAC data
- `frame_start`  out  1  one-`clk` pulse at the start of each frame

## Operation
- **Pixel phase.** Register `ph` toggles every `clk`.
  - `pix_en = (ph == 1)`.
  - `vga_clk = ph`.
- **Horizontal counter.** `hc` counts 0..H_TOT-1, where H_TOT = sum of the H parameters = 800. It advances only on `pix_en`.
- **Vertical counter.** `vc` counts 0..V_TOT-1, where V_TOT = 525. It increments when `hc` wraps from H_TOT-1 to 0.
  - At `hc` = H_TOT-1 and `vc` = V_TOT-1, both counters go to 0 on the same tick.
- **Coordinate output.** `tt_cm_x` = `hc[9:0]` and `tt_cm_y` = `vc[9:0]`, driven directly from the counter registers. They are also driven during blanking.
- **Raw flags**, computed from (`hc`, `vc`):
  - `act = hc < H_ACTIVE && vc < V_ACTIVE`
  - `hs_raw` is low for `hc` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. [656, 752)
  - `vs_raw` is low for `vc` in [490, 492)
- **Delay line.** `act`, `hs_raw` and `vs_raw` pass through a delay line of `CM_LAT` stages, each shifting only on `pix_en`.
- **Output register.** On each `pix_en`:
  - `vga_hs`, `vga_vs` and `vga_blank_n` load the delayed flags.
  - `vga_r/g/b` load `tt_cm_r/g/b` when the delayed `act` is 1, and load 0 otherwise.
- **Frame pulse.** `frame_start` is 1 for exactly the `pix_en` cycle on which the counters transition to (0,0).
- **Reset values:**
  - `ph`, `hc`, `vc` = 0
  - `vga_clk` = 0
  - `tt_cm_x`, `tt_cm_y` = 0
  - `vga_hs`, `vga_vs` = 1
  - `vga_blank_n` = 0
  - `vga_r/g/b` = 0
  - `frame_start` = 0
  - all delay-line stages cleared to hs/vs = 1, act = 0
- **Reset mid-frame.** Reset returns the block to the reset state on the next edge. After reset releases, the first pixel tick starts a fresh frame at (0,0). No partial-line sync glitch may appear: hs/vs stay high until their windows are reached.

## Timing
- One pixel tick = 2 `clk` cycles. Counters change on the `clk` edge where `pix_en` = 1.
- Coordinate (x,y) is presented on `tt_cm_x/y` at tick T.
  - The mapper must hold valid colour for it on the `pix_en` cycle of tick T+`CM_LAT`.
  - The pins show that pixel from the edge ending tick T+`CM_LAT`, i.e. total latency is `CM_LAT`+1 ticks.
- DAC data, blank and syncs change on the `clk` edge where `ph` goes 1→0. The DAC samples mid-pixel on the rising edge of `vga_clk`.
- `hs` low width = 96 ticks. `vs` low width = 2 full lines = 1600 ticks.
- Frame period = 800 × 525 = 420000 ticks = 840000 `clk` cycles.
- `frame_start` period = 840000 `clk` cycles. The first pulse occurs 840000 `clk` cycles after reset release.

## Structure
- Package `vga_timing_pkg` holds:
  - default timing constants
  - derived H_TOT/V_TOT and the sync window bounds
  - `rgb_t` packed struct {r, g, b} of 8 bits each
- Sub-module `vga_delay_line`:
  - parameters: width, depth (depth 0 = wire-through)
  - ports: enable, per-stage reset value
  - instantiated once for the {act, hs, vs} bundle

## Test plan
- **Reset values.** Hold `reset` 5 cycles → all outputs at their reset values. After release, `vga_clk` toggles every cycle and `tt_cm_x` reaches 1 at the 2nd `pix_en`.
- **Full-frame sweep.** Run one frame with `CM_LAT`=1 → 525 hs pulses each 96 ticks wide; a vs low window of exactly 1600 ticks starting at `vc`=490; `frame_start` period 840000 `clk` cycles.
- **Latency alignment.** Mapper model returns r=x[7:0], g=y[7:0], b=0xA5 after `CM_LAT` ticks (`CM_LAT`=0, 1, 4) → every visible pixel matches on the pins and `vga_blank_n` is high for exactly 640×480 ticks.
- **Blank forcing.** Mapper drives 0xFF on all channels constantly → `vga_r/g/b` = 0 whenever `vga_blank_n` = 0, including the ticks at x=639→640 and y=479→480.
- **Wrap.** Run to (799, 524) → the next tick gives (0,0) with `frame_start`=1 on that cycle only.
- **Reset mid-frame.** Assert `reset` at (300, 491) during vs low → `vga_vs` = 1 on the next edge, counters at 0, and the next vs falling edge occurs exactly 490 lines later.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared timing constants and pixel types for the VGA scanout path.
// Defaults give 640x480@60 Hz from a 25 MHz pixel tick.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;
  localparam int unsigned CM_LAT_DEF   = 1;

  function automatic int unsigned line_total(int unsigned act, int unsigned fp,
                                             int unsigned sync, int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  localparam int unsigned H_TOT_DEF    = line_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int unsigned V_TOT_DEF    = line_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);
  localparam int unsigned HS_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
  localparam int unsigned HS_END_DEF   = HS_START_DEF + H_SYNC_DEF;
  localparam int unsigned VS_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
  localparam int unsigned VS_END_DEF   = VS_START_DEF + V_SYNC_DEF;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
  } flags_t;

  localparam flags_t FLAGS_RST = '{act: 1'b0, hs: 1'b1, vs: 1'b1};

endpackage

// File: rtl/vga_scanout_if.sv
// Mapper coordinate/colour exchange plus VGA DAC pins of the scanout block.
interface vga_scanout_if;

  logic [9:0] tt_cm_x;
  logic [9:0] tt_cm_y;
  logic [7:0] tt_cm_r;
  logic [7:0] tt_cm_g;
  logic [7:0] tt_cm_b;
  logic       vga_clk;
  logic       vga_hs;
  logic       vga_vs;
  logic       vga_blank_n;
  logic       vga_sync_n;
  logic [7:0] vga_r;
  logic [7:0] vga_g;
  logic [7:0] vga_b;
  logic       frame_start;

  modport master (
    output tt_cm_x, tt_cm_y,
    input  tt_cm_r, tt_cm_g, tt_cm_b,
    output vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n,
    output vga_r, vga_g, vga_b, frame_start
  );

  modport slave (
    input  tt_cm_x, tt_cm_y,
    output tt_cm_r, tt_cm_g, tt_cm_b,
    input  vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n,
    input  vga_r, vga_g, vga_b, frame_start
  );

endinterface

// File: rtl/vga_delay_line.sv
// Enable-gated shift register with a per-stage reset value; DEPTH 0 is a wire.
module vga_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ok;
    assign unused_ok = ^{clk, reset, en, rst_val};
    assign q = d;
  end else begin : g_shift
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= rst_val;
      end else if (en) begin
        stage[0] <= d;
        for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_scanout.sv
// VGA raster generator: presents coordinates to the colour mapper and drives
// the DAC pins with sync/blank realigned to the mapper's returned colour.
module vga_scanout
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned CM_LAT   = CM_LAT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  vga_scanout_if.master bus
);

  localparam int unsigned H_TOT = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOT = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_LO  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_HI  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_LO  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_HI  = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic       ph;
  logic       pix_en;
  logic [9:0] hc;
  logic [9:0] vc;
  flags_t     raw;
  flags_t     dly;
  rgb_t       pix_q;
  logic       hs_q;
  logic       vs_q;
  logic       blank_q;

  always_ff @(posedge clk) begin
    if (reset) ph <= 1'b0;
    else       ph <= ~ph;
  end

  assign pix_en = ph;

  always_ff @(posedge clk) begin
    if (reset) begin
      hc <= '0;
      vc <= '0;
    end else if (pix_en) begin
      if (hc == H_LAST) begin
        hc <= '0;
        vc <= (vc == V_LAST) ? '0 : vc + 10'd1;
      end else begin
        hc <= hc + 10'd1;
      end
    end
  end

  always_comb begin
    raw     = FLAGS_RST;
    raw.act = (hc < H_ACT) && (vc < V_ACT);
    raw.hs  = !((hc >= HS_LO) && (hc < HS_HI));
    raw.vs  = !((vc >= VS_LO) && (vc < VS_HI));
  end

  // Flags wait CM_LAT ticks so they line up with the mapper's colour return.
  vga_delay_line #(
    .WIDTH($bits(flags_t)),
    .DEPTH(CM_LAT)
  ) u_flag_dly (
    .clk    (clk),
    .reset  (reset),
    .en     (pix_en),
    .rst_val(FLAGS_RST),
    .d      (raw),
    .q      (dly)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      pix_q   <= '0;
    end else if (pix_en) begin
      hs_q    <= dly.hs;
      vs_q    <= dly.vs;
      blank_q <= dly.act;
      pix_q   <= dly.act ? rgb_t'({bus.tt_cm_r, bus.tt_cm_g, bus.tt_cm_b}) : '0;
    end
  end

  assign bus.tt_cm_x     = hc;
  assign bus.tt_cm_y     = vc;
  assign bus.vga_clk     = ph;
  assign bus.vga_hs      = hs_q;
  assign bus.vga_vs      = vs_q;
  assign bus.vga_blank_n = blank_q;
  assign bus.vga_sync_n  = 1'b0;
  assign bus.vga_r       = pix_q.r;
  assign bus.vga_g       = pix_q.g;
  assign bus.vga_b       = pix_q.b;
  // Combinational from registers: high only during the pix_en cycle that wraps to (0,0).
  assign bus.frame_start = pix_en && (hc == H_LAST) && (vc == V_LAST);

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: one full-size instance plus three shrunken rasters at
// CM_LAT 0/1/4, all checked every clk against an absolute-tick raster model.
module tb_vga_scanout;
  import vga_timing_pkg::*;

  localparam int NI = 4;
  localparam int HA  [NI] = '{640, 16, 16, 16};
  localparam int HF  [NI] = '{16, 2, 2, 2};
  localparam int HSW [NI] = '{96, 4, 4, 4};
  localparam int HB  [NI] = '{48, 3, 3, 3};
  localparam int VA  [NI] = '{480, 12, 12, 12};
  localparam int VF  [NI] = '{10, 2, 2, 2};
  localparam int VSW [NI] = '{2, 2, 2, 2};
  localparam int VB  [NI] = '{33, 3, 3, 3};
  localparam int LAT [NI] = '{1, 0, 1, 4};
  localparam int HT_S = 25;
  localparam int FT_S = 25 * 19;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       vclk;
    logic       hs;
    logic       vs;
    logic       blank_n;
    logic       sync_n;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       fs;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  rgb_t drv [NI];
  obs_t obs [NI];

  always #10 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    vga_scanout_if bus ();
    vga_scanout #(
      .H_ACTIVE(HA[g]), .H_FP(HF[g]), .H_SYNC(HSW[g]), .H_BP(HB[g]),
      .V_ACTIVE(VA[g]), .V_FP(VF[g]), .V_SYNC(VSW[g]), .V_BP(VB[g]),
      .CM_LAT(LAT[g])
    ) u_dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
    );
    assign bus.tt_cm_r = drv[g].r;
    assign bus.tt_cm_g = drv[g].g;
    assign bus.tt_cm_b = drv[g].b;
    assign obs[g] = {bus.tt_cm_x, bus.tt_cm_y, bus.vga_clk, bus.vga_hs, bus.vga_vs,
                     bus.vga_blank_n, bus.vga_sync_n, bus.vga_r, bus.vga_g, bus.vga_b,
                     bus.frame_start};
  end

  int   k = -1;        // clk edges since the last edge that sampled reset high
  int   mode = 1;      // 0 random colour, 1 coordinate pattern, 2 all 0xFF
  int   n_pass = 0;
  int   n_checks = 0;
  rgb_t col [NI][16];  // colour the mapper returned, indexed by absolute tick mod 16
  int   hs_run [NI], vs_run [NI], blank_cnt [NI], hs_falls [NI], last_fs [NI];
  bit   hs_ok [NI], vs_ok [NI], vs_arm [NI], prev_hs [NI], prev_vs [NI];

  function automatic int h_tot(int g);
    return HA[g] + HF[g] + HSW[g] + HB[g];
  endfunction

  function automatic int v_tot(int g);
    return VA[g] + VF[g] + VSW[g] + VB[g];
  endfunction

  task automatic check(input string tag, input int idx, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s[%0d] k=%0d got=%h expected=%h", tag, idx, k, got, exp);
  endtask

  // Pins after m pixel ticks show the pixel presented at tick m-1-CM_LAT.
  function automatic obs_t expect_obs(int g, int kk);
    obs_t e;
    int ht, ft, m, pos, p, q, px, py;
    ht = h_tot(g);
    ft = ht * v_tot(g);
    m = kk / 2;
    pos = m % ft;
    e = '0;
    e.x = 10'(pos % ht);
    e.y = 10'(pos / ht);
    e.vclk = (kk % 2 == 1);
    e.fs = (kk % 2 == 1) && (pos == ft - 1);
    e.hs = 1'b1;
    e.vs = 1'b1;
    p = m - 1 - LAT[g];
    if (p >= 0) begin
      q = p % ft;
      px = q % ht;
      py = q / ht;
      e.hs = !(px >= HA[g] + HF[g] && px < HA[g] + HF[g] + HSW[g]);
      e.vs = !(py >= VA[g] + VF[g] && py < VA[g] + VF[g] + VSW[g]);
      e.blank_n = (px < HA[g]) && (py < VA[g]);
      if (e.blank_n) {e.r, e.g, e.b} = col[g][p % 16];
    end
    return e;
  endfunction

  task automatic measure(int g);
    int ht;
    ht = h_tot(g);
    if (reset) begin
      hs_run[g] = 0; vs_run[g] = 0; hs_ok[g] = 0; vs_ok[g] = 0;
      blank_cnt[g] = 0; hs_falls[g] = 0; last_fs[g] = -1;
      vs_arm[g] = 1; prev_hs[g] = 1; prev_vs[g] = 1;
    end else begin
      if (obs[g].blank_n) blank_cnt[g]++;
      if (prev_hs[g] && !obs[g].hs) hs_falls[g]++;
      if (!obs[g].hs) hs_run[g]++;
      else begin
        if (hs_ok[g] && hs_run[g] != 0) check("hs_width", g, 64'(hs_run[g]), 64'(2 * HSW[g]));
        hs_run[g] = 0;
        hs_ok[g] = 1;
      end
      if (!obs[g].vs) vs_run[g]++;
      else begin
        if (vs_ok[g] && vs_run[g] != 0) check("vs_width", g, 64'(vs_run[g]), 64'(2 * VSW[g] * ht));
        vs_run[g] = 0;
        vs_ok[g] = 1;
      end
      if (vs_arm[g] && prev_vs[g] && !obs[g].vs) begin
        check("vs_first_fall", g, 64'(k), 64'(2 * ((VA[g] + VF[g]) * ht + LAT[g] + 1)));
        vs_arm[g] = 0;
      end
      if (obs[g].fs) begin
        if (last_fs[g] >= 0) begin
          check("fs_period", g, 64'(k - last_fs[g]), 64'(2 * ht * v_tot(g)));
          check("blank_cycles", g, 64'(blank_cnt[g]), 64'(2 * HA[g] * VA[g]));
          check("hs_pulses", g, 64'(hs_falls[g]), 64'(v_tot(g)));
        end
        last_fs[g] = k;
        blank_cnt[g] = 0;
        hs_falls[g] = 0;
      end
      prev_hs[g] = obs[g].hs;
      prev_vs[g] = obs[g].vs;
    end
  endtask

  // Mapper: during tick t return the colour for the coordinate of tick t-CM_LAT.
  task automatic drive();
    int ht, ft, q, pos;
    logic [9:0] px, py;
    rgb_t c;
    if (k % 2 != 0) return;
    for (int g = 0; g < NI; g++) begin
      ht = h_tot(g);
      ft = ht * v_tot(g);
      q = k / 2 - LAT[g];
      c = 24'($urandom);
      if (q >= 0) begin
        pos = q % ft;
        px = 10'(pos % ht);
        py = 10'(pos / ht);
        if (mode == 1) c = {px[7:0], py[7:0], 8'hA5};
        else if (mode == 2) c = '1;
        col[g][q % 16] = c;
      end
      drv[g] = c;
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (reset) k = 0;
    else k++;
    for (int g = 0; g < NI; g++) begin
      check("pins", g, 64'(obs[g]), 64'(expect_obs(g, k)));
      measure(g);
    end
    drive();
  endtask

  initial begin
    int target;
    for (int g = 0; g < NI; g++) drv[g] = '0;
    reset = 1'b1;
    repeat (5) step();
    reset = 1'b0;

    mode = 1;
    repeat (2 * FT_S) step();
    mode = 2;
    repeat (4 * FT_S) step();

    // Run into the second vs-low line of the fourth small frame, then reset.
    mode = 0;
    target = 2 * (3 * FT_S + 15 * HT_S + int'($urandom_range(0, HT_S - 1)));
    for (int i = 0; i < 2 * FT_S && k != target; i++) step();
    check("reach_target", 0, 64'(k), 64'(target));
    for (int g = 1; g < NI; g++) check("vs_low_pre_rst", g, 64'(obs[g].vs), 64'(0));

    reset = 1'b1;
    step();
    for (int g = 1; g < NI; g++) begin
      check("vs_after_rst", g, 64'(obs[g].vs), 64'(1));
      check("xy_after_rst", g, 64'({obs[g].x, obs[g].y}), 64'(0));
    end
    repeat ($urandom_range(0, 2)) step();
    reset = 1'b0;
    repeat (4 * FT_S + 40) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
